// File: rtl/cordic_phase_feeder_pkg.sv
// Shared constants for the CORDIC phase feeder: word width derivation,
// gain-compensated start vector and phase-to-Z angle scaling.
package cordic_phase_feeder_pkg;

  // 1/K of the CORDIC rotation chain (0.60725) in Q16.
  localparam int CORDIC_GAIN_Q16 = 32'sd39797;

  function automatic int calc_bitwidth(input int n_int, input int n_frac);
    return n_int - n_frac + 32'sd1;
  endfunction

  function automatic int gain_x_init(input int bw);
    longint prod;
    prod = longint'(CORDIC_GAIN_Q16) * (64'sd1 <<< (bw - 32'sd1));
    return int'((prod + 64'sd32768) >>> 32'sd16);
  endfunction

  // Z LSB weighs pi / 2^BITWIDTH, so [-pi/2, pi/2) spans the full signed range.
  function automatic int z_slice_lsb(input int phase_bw, input int bw);
    return phase_bw - bw - 32'sd1;
  endfunction

endpackage

// File: rtl/cordic_phase_feeder_pipe_delay.sv
// Fixed-depth shift register for side-band flags; shifts every cycle,
// async reset and synchronous clear both empty the pipe.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  // Next-state of the shift chain, zeroed on clear.
  always_comb begin
    stage_d = stage_q;
    if (clr_i) begin
      stage_d = '0;
    end else begin
      stage_d[0] = d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_feeder.sv
// Phase accumulator feeding a rotation-mode CORDIC: folds the phase into
// [-pi/2, pi/2) with a quadrant-flip flag and aligns side-band flags.
module cordic_phase_feeder
  import cordic_phase_feeder_pkg::*;
#(
  parameter int N_INT          = 0,
  parameter int N_FRAC         = -7,
  parameter int PHASE_BITWIDTH = 16,
  parameter int N_STAGES       = 8,
  parameter int X_INIT         = gain_x_init(calc_bitwidth(N_INT, N_FRAC)),
  localparam int BITWIDTH      = calc_bitwidth(N_INT, N_FRAC)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [PHASE_BITWIDTH-1:0] freq_word_i,
  input  logic [PHASE_BITWIDTH-1:0] phase_offset_i,
  output logic signed [BITWIDTH-1:0] X_o,
  output logic signed [BITWIDTH-1:0] Y_o,
  output logic signed [BITWIDTH-1:0] Z_o,
  output logic                      valid_o,
  output logic                      flip_o,
  output logic                      valid_aln_o,
  output logic                      flip_aln_o
);

  localparam int Z_LSB = z_slice_lsb(PHASE_BITWIDTH, BITWIDTH);

  logic [PHASE_BITWIDTH-1:0] acc_q, acc_d;
  logic [PHASE_BITWIDTH-1:0] phase_s, fold_s;
  logic                      flip_s;
  logic signed [BITWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                      valid_q, valid_d, flip_q, flip_d;
  logic [1:0]                aln_s;

  // Phase fold: second/third quadrant angles are rotated by pi and flagged.
  always_comb begin
    phase_s = acc_q + phase_offset_i;
    flip_s  = phase_s[PHASE_BITWIDTH-1] ^ phase_s[PHASE_BITWIDTH-2];
    fold_s  = phase_s ^ {flip_s, {(PHASE_BITWIDTH-1){1'b0}}};
  end

  // Next-state: clear wins over strobe; idle cycles hold the vector.
  always_comb begin
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    flip_d  = flip_q;
    valid_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d   = acc_q + freq_word_i;
      x_d     = BITWIDTH'(X_INIT);
      y_d     = '0;
      z_d     = BITWIDTH'(fold_s >> Z_LSB);
      flip_d  = flip_s;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Accumulator and output vector registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      flip_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      flip_q  <= flip_d;
      valid_q <= valid_d;
    end
  end

  pipe_delay #(
    .WIDTH(2),
    .DEPTH(N_STAGES)
  ) u_sideband (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .clr_i (clr_i),
    .d_i   ({valid_q, flip_q}),
    .q_o   (aln_s)
  );

  assign X_o         = x_q;
  assign Y_o         = y_q;
  assign Z_o         = z_q;
  assign valid_o     = valid_q;
  assign flip_o      = flip_q;
  assign valid_aln_o = aln_s[1];
  assign flip_aln_o  = aln_s[0];

endmodule

// File: tb/tb_cordic_phase_feeder.sv
// Directed self-checking bench for cordic_phase_feeder (16-bit phase, 8-bit word, 8 stages).
module tb_cordic_phase_feeder;

  logic clk = 1'b0;
  logic rstn, en, clr;
  logic [15:0] freq, off;
  logic signed [7:0] x, y, z;
  logic valid, flip, valid_aln, flip_aln;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic        clr;
    logic [15:0] freq;
    logic [15:0] off;
    logic        valid;
    logic signed [7:0] z;
    logic        flip;
  } vec_t;

  vec_t vecs[15];
  logic [16:0] en_pat, flip_pat;

  always #5 clk = ~clk;

  cordic_phase_feeder #(
    .N_INT(0), .N_FRAC(-7), .PHASE_BITWIDTH(16), .N_STAGES(8)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr),
    .freq_word_i(freq), .phase_offset_i(off),
    .X_o(x), .Y_o(y), .Z_o(z), .valid_o(valid), .flip_o(flip),
    .valid_aln_o(valid_aln), .flip_aln_o(flip_aln)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic v, input logic signed [7:0] ez, input logic ef);
    chk({tag, " valid"}, valid, v);
    chk({tag, " Z"}, z, ez);
    chk({tag, " flip"}, flip, ef);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " X"}, x, 32'd0);
    chk({tag, " Y"}, y, 32'd0);
    chk({tag, " Z"}, z, 32'd0);
    chk({tag, " valid"}, valid, 32'd0);
    chk({tag, " flip"}, flip, 32'd0);
    chk({tag, " valid_aln"}, valid_aln, 32'd0);
    chk({tag, " flip_aln"}, flip_aln, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1,  8'sd0,   1'b0};
    vecs[1]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1,  8'sd32,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1,  8'sd64,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1,  8'sd96,  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, -8'sd128, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, -8'sd96,  1'b1};
    vecs[6]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, -8'sd64,  1'b1};
    vecs[7]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, -8'sd32,  1'b1};
    vecs[8]  = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1,  8'sd0,   1'b1};
    vecs[9]  = '{1'b0, 1'b0, 16'h1000, 16'h0000, 1'b0,  8'sd0,   1'b1};
    vecs[10] = '{1'b1, 1'b0, 16'h1000, 16'h4000, 1'b1, -8'sd96,  1'b0};
    vecs[11] = '{1'b1, 1'b1, 16'h1000, 16'h4000, 1'b0, -8'sd96,  1'b0};
    vecs[12] = '{1'b1, 1'b0, 16'h0000, 16'h4000, 1'b1, -8'sd128, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 16'h4000, 1'b1, -8'sd128, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1,  8'sd0,   1'b0};

    rstn = 1'b0; en = 1'b0; clr = 1'b0; freq = 16'h0000; off = 16'h0000;
    #12;
    chk_all_zero("por");
    rstn = 1'b1;

    // Main table: full-rate sweep, idle hold, offset, clear priority.
    foreach (vecs[i]) begin
      en = vecs[i].en; clr = vecs[i].clr; freq = vecs[i].freq; off = vecs[i].off;
      tick();
      chk_vec($sformatf("vec%0d", i), vecs[i].valid, vecs[i].z, vecs[i].flip);
      if (vecs[i].en && !vecs[i].clr) begin
        chk($sformatf("vec%0d X", i), x, 32'd78);
        chk($sformatf("vec%0d Y", i), y, 32'd0);
      end
    end
    clr = 1'b0;

    // Wrap: acc reaches 0xF000 then rolls over to 0 without a stall.
    en = 1'b1; freq = 16'hF000; off = 16'h0000;
    tick(); chk_vec("wrap0", 1'b1, 8'sd0, 1'b0);
    freq = 16'h1000;
    tick(); chk_vec("wrap1", 1'b1, -8'sd32, 1'b0);
    tick(); chk_vec("wrap2", 1'b1, 8'sd0, 1'b0);

    // Side-band alignment: en 1,0,1,1 after a clear.
    en = 1'b0; clr = 1'b1;
    tick(); chk("aln clr valid", valid, 32'd0);
    clr = 1'b0; freq = 16'h4000; off = 16'h0000;
    en_pat   = 17'h0001A;
    flip_pat = 17'h1FFF8;
    for (int i = 1; i <= 16; i++) begin
      en = en_pat[i];
      tick();
      chk($sformatf("aln%0d valid", i), valid, en_pat[i]);
      chk($sformatf("aln%0d flip", i), flip, flip_pat[i]);
      chk($sformatf("aln%0d valid_aln", i), valid_aln, (i >= 9) ? en_pat[i-8] : 1'b0);
      chk($sformatf("aln%0d flip_aln", i), flip_aln, (i >= 9) ? flip_pat[i-8] : 1'b0);
    end

    // Clear together with strobe mid-stream discards in-flight side-band.
    en = 1'b1; freq = 16'h1000; off = 16'h2000;
    tick(); chk_vec("cs0", 1'b1, -8'sd64, 1'b0);
    clr = 1'b1;
    tick(); chk_vec("cs1", 1'b0, -8'sd64, 1'b0);
    clr = 1'b0; en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("cs valid_aln+%0d", k), valid_aln, 32'd0);
    end
    en = 1'b1;
    tick(); chk_vec("cs next", 1'b1, 8'sd64, 1'b0);

    // Asynchronous reset mid-stream, then first strobe issues the offset.
    tick(); tick(); tick();
    #2 rstn = 1'b0;
    #1 chk_all_zero("async rst");
    #1 rstn = 1'b1;
    en = 1'b1; freq = 16'h1000; off = 16'h0000;
    tick();
    chk_vec("post rst", 1'b1, 8'sd0, 1'b0);
    chk("post rst X", x, 32'd78);
    en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("rst valid_aln+%0d", k), valid_aln, (k == 8) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_phase_feeder.md
CORDIC_PHASE_FEEDER -- requirements
Module: cordic_phase_feeder

Interface
REQ-001 Parameter N_INT, default 0: integer bits of CORDIC datapath word.
REQ-002 Parameter N_FRAC, default -7: fractional exponent; BITWIDTH = N_INT - N_FRAC + 1 (default 8).
REQ-003 Parameter PHASE_BITWIDTH, default 16: accumulator width; SHALL be >= BITWIDTH + 1.
REQ-004 Parameter N_STAGES, default 8: downstream CORDIC slice count for side-band alignment; SHALL be >= 1.
REQ-005 Parameter X_INIT, default 78: gain-compensated start X, round(0.60725 * 2^(BITWIDTH-1)).
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rstn_i  in  1  asynchronous, active-low reset.
REQ-008 en_i  in  1  sample strobe; one CORDIC vector issued per cycle high.
REQ-009 clr_i  in  1  synchronous clear of accumulator and side-band pipe.
REQ-010 freq_word_i  in  PHASE_BITWIDTH  unsigned phase increment per strobe.
REQ-011 phase_offset_i  in  PHASE_BITWIDTH  unsigned phase offset, full turn = 2^PHASE_BITWIDTH.
REQ-012 X_o, Y_o, Z_o  out  BITWIDTH each, signed  initial vector to first CORDIC slice.
REQ-013 valid_o, flip_o  out  1 each  X/Y/Z valid; quadrant-flip flag for same vector.
REQ-014 valid_aln_o, flip_aln_o  out  1 each  valid_o/flip_o delayed N_STAGES cycles.

Function
REQ-015 Accumulator acc (PHASE_BITWIDTH, unsigned) SHALL wrap modulo 2^PHASE_BITWIDTH, no saturation.
REQ-016 Phase p = acc + phase_offset_i, modulo 2^PHASE_BITWIDTH, using pre-update acc.
REQ-017 Edge with en_i=1, clr_i=0: register X_o=X_INIT, Y_o=0, Z_o, flip_o from p; acc <= acc + freq_word_i; valid_o <= 1.
REQ-018 Fold: if p[MSB]==p[MSB-1] then flip=0, Z = p[MSB-1 : MSB-BITWIDTH]; else flip=1, Z = same slice of p with MSB toggled (angle - pi).
REQ-019 Z scaling: [-pi/2, pi/2) maps linearly onto full signed BITWIDTH range; slice angle table uses the same scaling.
REQ-020 Edge with en_i=0, clr_i=0: valid_o <= 0; X_o, Y_o, Z_o, flip_o, acc hold.
REQ-021 Latency: en_i sampled at edge k -> vector on outputs after edge k; one vector per cycle at full rate.
REQ-022 Side-band pipe: N_STAGES-deep shift of {valid_o, flip_o}, shifting every cycle regardless of en_i.
REQ-023 clr_i=1 (priority over en_i): acc <= 0, valid_o <= 0, all pipe stages <= 0; X_o/Y_o/Z_o/flip_o hold.
REQ-024 freq_word_i, phase_offset_i changes take effect at next strobe; no glitch or extra vector.

Reset
REQ-025 rstn_i low SHALL immediately clear acc, X_o, Y_o, Z_o, valid_o, flip_o and all pipe stages to 0, independent of clk_i.
REQ-026 Reset asserted mid-stream SHALL discard in-flight side-band; first strobe after release issues p = phase_offset_i.

Structure
REQ-027 Shared package holds BITWIDTH derivation, CORDIC gain constant (X_INIT), Z angle scaling constant.
REQ-028 Side-band alignment implemented as sub-module pipe_delay (parameters WIDTH, DEPTH; async reset, sync clear).

Verification (PHASE_BITWIDTH=16, BITWIDTH=8, N_STAGES=8)
REQ-029 Reset: rstn_i low mid-stream -> all outputs 0 without clock edge; first vector after release Z=0, flip=0.
REQ-030 freq=0x1000, offset=0, en_i high: Z/flip = 0/0, 32/0, 64/0, 96/0, then p=0x4000 -> -128/1, p=0x8000 -> 0/1; X_o=78, Y_o=0.
REQ-031 Wrap: acc=0xF000, freq=0x1000 -> next p=0x0000, Z=0, flip=0, no stall.
REQ-032 freq=0, offset=0x4000, en_i high -> constant Z=-128, flip=1, valid_o high each cycle.
REQ-033 en_i pattern 1,0,1,1 -> valid_o 1,0,1,1 one cycle later; valid_aln_o/flip_aln_o same pattern exactly 8 cycles after valid_o/flip_o.
REQ-034 clr_i and en_i high together mid-stream -> valid_o=0, valid_aln_o low 8 cycles later, next strobe Z=offset-derived.
